regfile_2r1w_sb: RTL and testbench



---
 rtl/regfile_2r1w_sb_pkg.sv | 11 +
 rtl/regfile_2r1w_sb_if.sv | 41 ++++
 rtl/regfile_2r1w_sb_scoreboard.sv | 59 +++++
 rtl/regfile_2r1w_sb.sv | 69 ++++++
 tb/tb_regfile_2r1w_sb.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_2r1w_sb_pkg.sv
// Shared defaults and types for the register file slice.
package regfile_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_N     = 32;
    localparam int DEFAULT_AW    = $clog2(DEFAULT_N);

    typedef logic [DEFAULT_WIDTH-1:0] data_t;
    typedef logic [DEFAULT_AW-1:0]    adr_t;

endpackage

// File: rtl/regfile_2r1w_sb_if.sv
// Decode/writeback/issue bundle of the register file.
interface regfile_2r1w_sb_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N
);
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    logic             rd_en_a;
    logic [AW-1:0]    rd_adr_a;
    logic [WIDTH-1:0] rd_data_a;
    logic             rd_busy_a;
    logic             rd_en_b;
    logic [AW-1:0]    rd_adr_b;
    logic [WIDTH-1:0] rd_data_b;
    logic             rd_busy_b;
    logic             wr_en;
    logic [AW-1:0]    wr_adr;
    logic [WIDTH-1:0] wr_data;
    logic             issue_en;
    logic [AW-1:0]    issue_adr;
    logic             issue_ready;
    logic [CW-1:0]    busy_cnt;

    modport master (
        output rd_en_a, rd_adr_a, rd_en_b, rd_adr_b,
        output wr_en, wr_adr, wr_data, issue_en, issue_adr,
        input  rd_data_a, rd_busy_a, rd_data_b, rd_busy_b,
        input  issue_ready, busy_cnt
    );

    modport slave (
        input  rd_en_a, rd_adr_a, rd_en_b, rd_adr_b,
        input  wr_en, wr_adr, wr_data, issue_en, issue_adr,
        output rd_data_a, rd_busy_a, rd_data_b, rd_busy_b,
        output issue_ready, busy_cnt
    );

endinterface

// File: rtl/regfile_2r1w_sb_scoreboard.sv
// Busy scoreboard: one bit per register, issue acceptance and busy count.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(N),
    localparam int CW      = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_adr,
    input  logic          issue_en,
    input  logic [AW-1:0] issue_adr,
    output logic [N-1:0]  busy,
    output logic          issue_ready,
    output logic [CW-1:0] busy_cnt
);

    logic          issue_zero;
    logic          wr_ok;
    logic          set_ok;
    logic          cnt_inc;
    logic          cnt_dec;
    logic [N-1:0]  busy_nxt;

    // Acceptance and next busy vector; a set on the written register wins.
    always_comb begin
        issue_zero  = ZERO_REG && (issue_adr == '0);
        wr_ok       = wr_en && !(ZERO_REG && (wr_adr == '0));
        issue_ready = issue_zero || !busy[issue_adr] ||
                      (wr_en && (wr_adr == issue_adr));
        set_ok      = issue_en && issue_ready && !issue_zero;
        cnt_inc     = set_ok && !busy[issue_adr];
        cnt_dec     = wr_ok && busy[wr_adr] &&
                      !(set_ok && (issue_adr == wr_adr));
        busy_nxt    = busy;
        if (wr_ok)
            busy_nxt[wr_adr] = 1'b0;
        if (set_ok)
            busy_nxt[issue_adr] = 1'b1;
    end

    // Busy bits and running count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy <= busy_nxt;
            if (cnt_inc && !cnt_dec)
                busy_cnt <= busy_cnt + 1'b1;
            else if (cnt_dec && !cnt_inc)
                busy_cnt <= busy_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/regfile_2r1w_sb.sv
// Two-read, one-write register file with busy scoreboard.
module regfile_2r1w_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int N        = DEFAULT_N,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    regfile_2r1w_sb_if.slave bus
);

    localparam int AW = $clog2(N);

    logic [WIDTH-1:0] mem [N];
    logic [N-1:0]     busy;
    logic             wr_ok;

    assign wr_ok = bus.wr_en && !(ZERO_REG && (bus.wr_adr == '0));

    // Returns {busy, data} for one read port.
    function automatic logic [WIDTH:0] read_port(input logic en, input logic [AW-1:0] adr);
        logic [WIDTH:0] r;
        r = '0;
        if (en) begin
            if (ZERO_REG && (adr == '0))
                r = '0;
            else if (BYPASS && bus.wr_en && (bus.wr_adr == adr))
                r = {1'b0, bus.wr_data};
            else
                r = {busy[adr], mem[adr]};
        end
        return r;
    endfunction

    // Register storage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N; i++)
                mem[i] <= '0;
        end else if (wr_ok) begin
            mem[bus.wr_adr] <= bus.wr_data;
        end
    end

    // Combinational read ports.
    always_comb begin
        {bus.rd_busy_a, bus.rd_data_a} = read_port(bus.rd_en_a, bus.rd_adr_a);
        {bus.rd_busy_b, bus.rd_data_b} = read_port(bus.rd_en_b, bus.rd_adr_b);
    end

    reg_scoreboard #(
        .N        (N),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (bus.wr_en),
        .wr_adr      (bus.wr_adr),
        .issue_en    (bus.issue_en),
        .issue_adr   (bus.issue_adr),
        .busy        (busy),
        .issue_ready (bus.issue_ready),
        .busy_cnt    (bus.busy_cnt)
    );

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Directed bench: bus1 drives a BYPASS=1 instance, bus0 mirrors the same
// inputs into a BYPASS=0 instance.
module tb_regfile_2r1w_sb;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    regfile_2r1w_sb_if #(.WIDTH(32), .N(32)) bus1 ();
    regfile_2r1w_sb_if #(.WIDTH(32), .N(32)) bus0 ();

    assign bus0.rd_en_a   = bus1.rd_en_a;
    assign bus0.rd_adr_a  = bus1.rd_adr_a;
    assign bus0.rd_en_b   = bus1.rd_en_b;
    assign bus0.rd_adr_b  = bus1.rd_adr_b;
    assign bus0.wr_en     = bus1.wr_en;
    assign bus0.wr_adr    = bus1.wr_adr;
    assign bus0.wr_data   = bus1.wr_data;
    assign bus0.issue_en  = bus1.issue_en;
    assign bus0.issue_adr = bus1.issue_adr;

    regfile_2r1w_sb #(.WIDTH(32), .N(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    regfile_2r1w_sb #(.WIDTH(32), .N(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one edge, then leave time for new inputs to be driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus1.wr_en    = 1'b0;
        bus1.wr_adr   = '0;
        bus1.wr_data  = '0;
        bus1.issue_en = 1'b0;
        bus1.issue_adr = '0;
    endtask

    task automatic read_a(input int adr);
        bus1.rd_en_a  = 1'b1;
        bus1.rd_adr_a = adr[4:0];
        #1;
    endtask

    initial begin
        reset = 1'b0;
        bus1.rd_en_a = 1'b0;
        bus1.rd_adr_a = '0;
        bus1.rd_en_b = 1'b0;
        bus1.rd_adr_b = '0;
        idle();
        tick();
        tick();
        check("reset_busy_cnt", 64'(bus1.busy_cnt), 0);
        reset = 1'b1;
        tick();

        // Everything reads zero after reset.
        bus1.rd_en_a = 1'b1;
        bus1.rd_en_b = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus1.rd_adr_a = 5'(i);
            bus1.rd_adr_b = 5'(31 - i);
            #1;
            check("rst_data_a", 64'(bus1.rd_data_a), 0);
            check("rst_data_b", 64'(bus1.rd_data_b), 0);
            check("rst_busy_a", 64'(bus1.rd_busy_a), 0);
            check("rst_busy_b", 64'(bus1.rd_busy_b), 0);
        end
        check("rst_cnt", 64'(bus1.busy_cnt), 0);

        // Write r5: bypass vs. no bypass.
        bus1.wr_en = 1'b1; bus1.wr_adr = 5'd5; bus1.wr_data = 32'hDEADBEEF;
        bus1.rd_adr_b = 5'd5;
        read_a(5);
        check("byp_same_cycle", 64'(bus1.rd_data_a), 64'hDEADBEEF);
        check("byp_port_b", 64'(bus1.rd_data_b), 64'hDEADBEEF);
        check("nobyp_same_cycle", 64'(bus0.rd_data_a), 0);
        tick();
        idle();
        #1;
        check("byp_next", 64'(bus1.rd_data_a), 64'hDEADBEEF);
        check("nobyp_next", 64'(bus0.rd_data_a), 64'hDEADBEEF);
        bus1.rd_en_a = 1'b0;
        #1;
        check("rd_disabled", 64'(bus1.rd_data_a), 0);
        check("rd_b_enabled", 64'(bus1.rd_data_b), 64'hDEADBEEF);

        // r0 is hard-wired zero and never busy.
        bus1.wr_en = 1'b1; bus1.wr_adr = 5'd0; bus1.wr_data = 32'h1234;
        read_a(0);
        check("r0_bypass", 64'(bus1.rd_data_a), 0);
        tick();
        idle();
        read_a(0);
        check("r0_data", 64'(bus1.rd_data_a), 0);
        check("r0_data_nb", 64'(bus0.rd_data_a), 0);
        bus1.issue_en = 1'b1; bus1.issue_adr = 5'd0;
        #1;
        check("r0_issue_ready", 64'(bus1.issue_ready), 1);
        tick();
        idle();
        #1;
        check("r0_cnt", 64'(bus1.busy_cnt), 0);
        check("r0_busy", 64'(bus1.rd_busy_a), 0);

        // Issue r7, retry while busy, then clear by writeback.
        bus1.issue_en = 1'b1; bus1.issue_adr = 5'd7;
        read_a(7);
        check("r7_ready", 64'(bus1.issue_ready), 1);
        check("r7_busy_before", 64'(bus1.rd_busy_a), 0);
        tick();
        #1;
        check("r7_busy", 64'(bus1.rd_busy_a), 1);
        check("r7_cnt", 64'(bus1.busy_cnt), 1);
        check("r7_retry_ready", 64'(bus1.issue_ready), 0);
        tick();
        idle();
        #1;
        check("r7_cnt_hold", 64'(bus1.busy_cnt), 1);
        bus1.wr_en = 1'b1; bus1.wr_adr = 5'd7; bus1.wr_data = 32'h77;
        #1;
        check("r7_wr_busy_byp", 64'(bus1.rd_busy_a), 0);
        check("r7_wr_busy_nb", 64'(bus0.rd_busy_a), 1);
        tick();
        idle();
        #1;
        check("r7_cleared", 64'(bus1.rd_busy_a), 0);
        check("r7_cnt_zero", 64'(bus1.busy_cnt), 0);
        check("r7_data", 64'(bus1.rd_data_a), 64'h77);

        // Set wins when issue and write hit the same busy register.
        bus1.issue_en = 1'b1; bus1.issue_adr = 5'd9;
        tick();
        idle();
        read_a(9);
        check("r9_cnt", 64'(bus1.busy_cnt), 1);
        bus1.wr_en = 1'b1; bus1.wr_adr = 5'd9; bus1.wr_data = 32'hA5A5;
        bus1.issue_en = 1'b1; bus1.issue_adr = 5'd9;
        #1;
        check("r9_ready", 64'(bus1.issue_ready), 1);
        tick();
        idle();
        #1;
        check("r9_data", 64'(bus1.rd_data_a), 64'hA5A5);
        check("r9_busy", 64'(bus1.rd_busy_a), 1);
        check("r9_cnt_same", 64'(bus1.busy_cnt), 1);
        bus1.wr_en = 1'b1; bus1.wr_adr = 5'd9; bus1.wr_data = 32'h99;
        tick();
        idle();
        #1;
        check("r9_cnt_clear", 64'(bus1.busy_cnt), 0);

        // Issue r10, then write r10 while issuing r11: net count unchanged.
        bus1.issue_en = 1'b1; bus1.issue_adr = 5'd10;
        tick();
        bus1.issue_adr = 5'd11;
        bus1.wr_en = 1'b1; bus1.wr_adr = 5'd10; bus1.wr_data = 32'h10;
        tick();
        idle();
        bus1.rd_adr_b = 5'd11;
        read_a(10);
        check("swap_cnt", 64'(bus1.busy_cnt), 1);
        check("swap_r10", 64'(bus1.rd_busy_a), 0);
        check("swap_r11", 64'(bus1.rd_busy_b), 1);
        bus1.wr_en = 1'b1; bus1.wr_adr = 5'd11; bus1.wr_data = 32'h11;
        tick();
        idle();
        #1;
        check("swap_clear", 64'(bus1.busy_cnt), 0);

        // Reset overrides pending write and issue.
        bus1.issue_en = 1'b1; bus1.issue_adr = 5'd3;
        tick();
        bus1.issue_adr = 5'd4;
        tick();
        idle();
        #1;
        check("pre_rst_cnt", 64'(bus1.busy_cnt), 2);
        reset = 1'b0;
        bus1.wr_en = 1'b1; bus1.wr_adr = 5'd3; bus1.wr_data = 32'hFFFF;
        bus1.issue_en = 1'b1; bus1.issue_adr = 5'd6;
        tick();
        reset = 1'b1;
        idle();
        bus1.rd_adr_b = 5'd5;
        read_a(3);
        check("post_rst_cnt", 64'(bus1.busy_cnt), 0);
        check("post_rst_r3", 64'(bus1.rd_data_a), 0);
        check("post_rst_r3_busy", 64'(bus1.rd_busy_a), 0);
        check("post_rst_r5", 64'(bus1.rd_data_b), 0);
        read_a(6);
        check("post_rst_r6_busy", 64'(bus1.rd_busy_a), 0);
        read_a(4);
        check("post_rst_r4_busy", 64'(bus1.rd_busy_a), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
